// File: rtl/xorexec_mc.sv
// ---------------------------------------------------------------------------
// xorexec_mc - multi-channel xor executor
//
// Words arrive on a shared push port tagged with a channel number and are
// buffered in per-channel input FIFOs. A round-robin arbiter issues at most
// one word per clock into a single exec register that XORs the word with the
// channel key. In chained mode the result also becomes the new key. Results
// leave through a shared first-word-fall-through output FIFO with a channel tag.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ififo_push/_ch      push idata into input FIFO of channel ififo_ch
//   idata               push data
//   ififo_not_full      per-channel input FIFO has space (registered)
//   key_wr/_ch/_data    write key of channel key_ch
//   chain_en            1 = chained key, 0 = static key (sampled at issue)
//   ofifo_pop           consume output FIFO head
//   ofifo_rdy           output FIFO non-empty
//   odata, och          output FIFO head data and channel tag
//   ovf_err             sticky per-channel flag: push to a full channel
// ---------------------------------------------------------------------------
module xorexec_mc #(
   parameter int DWIDTH = 8,
   parameter int NCH    = 4,
   parameter int IDEPTH = 4,
   parameter int ODEPTH = 8,
   parameter logic [DWIDTH-1:0] KEY_INIT = {DWIDTH{1'b0}}
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ififo_push,
   input  logic [$clog2(NCH)-1:0]   ififo_ch,
   input  logic [DWIDTH-1:0]        idata,
   output logic [NCH-1:0]           ififo_not_full,
   input  logic                     key_wr,
   input  logic [$clog2(NCH)-1:0]   key_ch,
   input  logic [DWIDTH-1:0]        key_data,
   input  logic                     chain_en,
   input  logic                     ofifo_pop,
   output logic                     ofifo_rdy,
   output logic [DWIDTH-1:0]        odata,
   output logic [$clog2(NCH)-1:0]   och,
   output logic [NCH-1:0]           ovf_err
);
   localparam int CW  = $clog2(NCH);
   localparam int IAW = $clog2(IDEPTH);
   localparam int OAW = $clog2(ODEPTH);
   localparam logic [IAW:0]   IFULL  = (IAW+1)'(IDEPTH);
   localparam logic [OAW+1:0] OSLOTS = (OAW+2)'(ODEPTH);

   logic [1:0]        rst_sync_r;
   logic              rst_int_n_s;

   logic [DWIDTH-1:0] imem_r [NCH][IDEPTH];
   logic [IAW-1:0]    iwptr_r [NCH];
   logic [IAW-1:0]    irptr_r [NCH];
   logic [IAW:0]      icnt_r [NCH];
   logic [IAW:0]      icnt_nxt_s [NCH];
   logic [NCH-1:0]    not_full_r, ovf_r;
   logic [NCH-1:0]    nonempty_s, push_vec_s, accept_vec_s, issue_vec_s;

   logic [DWIDTH-1:0] key_r [NCH];
   logic [CW-1:0]     rr_ptr_r, win_s;
   logic              any_s, space_s, issue_s;
   logic [DWIDTH-1:0] result_s;

   logic              exec_valid_r;
   logic [DWIDTH-1:0] exec_data_r;
   logic [CW-1:0]     exec_ch_r;

   logic [DWIDTH-1:0] odmem_r [ODEPTH];
   logic [CW-1:0]     ocmem_r [ODEPTH];
   logic [OAW-1:0]    owptr_r, orptr_r, orptr_nxt_s;
   logic [OAW:0]      ocnt_r, ocnt_kept_s, ocnt_nxt_s;
   logic              opop_s, ordy_r;
   logic [DWIDTH-1:0] odata_r, odata_nxt_s;
   logic [CW-1:0]     och_r, och_nxt_s;

   // Reset synchronizer: assertion is immediate, release is aligned to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end
   assign rst_int_n_s = rst_sync_r[1];

   // Round-robin arbiter: scan downward so the lowest offset from rr_ptr wins.
   always_comb begin
      logic [CW-1:0] idx;
      win_s = rr_ptr_r;
      any_s = 1'b0;
      idx   = rr_ptr_r;
      for (int c = 0; c < NCH; c++) begin
         nonempty_s[c] = (icnt_r[c] != {(IAW+1){1'b0}});
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         idx   = rr_ptr_r + CW'(i);
         win_s = nonempty_s[idx] ? idx : win_s;
         any_s = any_s | nonempty_s[idx];
      end
   end

   // Issue gate counts the exec word as already occupying an output slot.
   always_comb begin
      space_s  = ({1'b0, ocnt_r} + {{(OAW+1){1'b0}}, exec_valid_r}) < OSLOTS;
      issue_s  = any_s & space_s;
      result_s = imem_r[win_s][irptr_r[win_s]] ^ key_r[win_s];
   end

   // Per-channel push acceptance; an issue in the same cycle frees a slot.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         issue_vec_s[c]  = issue_s && (win_s == CW'(c));
         push_vec_s[c]   = ififo_push && (ififo_ch == CW'(c));
         accept_vec_s[c] = push_vec_s[c] && ((icnt_r[c] < IFULL) || issue_vec_s[c]);
         icnt_nxt_s[c]   = icnt_r[c] + {{IAW{1'b0}}, accept_vec_s[c]}
                                     - {{IAW{1'b0}}, issue_vec_s[c]};
      end
   end

   // Input FIFO storage (no reset needed: pointers define validity).
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (accept_vec_s[c]) begin
            imem_r[c][iwptr_r[c]] <= idata;
         end
      end
   end

   // Input FIFO pointers, counts, registered not-full and sticky overflow.
   always_ff @(posedge clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         for (int c = 0; c < NCH; c++) begin
            iwptr_r[c] <= {IAW{1'b0}};
            irptr_r[c] <= {IAW{1'b0}};
            icnt_r[c]  <= {(IAW+1){1'b0}};
         end
         not_full_r <= {NCH{1'b1}};
         ovf_r      <= {NCH{1'b0}};
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (accept_vec_s[c]) begin
               iwptr_r[c] <= iwptr_r[c] + IAW'(1);
            end
            if (issue_vec_s[c]) begin
               irptr_r[c] <= irptr_r[c] + IAW'(1);
            end
            if (push_vec_s[c] && !accept_vec_s[c]) begin
               ovf_r[c] <= 1'b1;
            end
            icnt_r[c]     <= icnt_nxt_s[c];
            not_full_r[c] <= (icnt_nxt_s[c] < IFULL);
         end
      end
   end

   // Exec register, RR pointer and keys; an explicit key write beats chaining.
   always_ff @(posedge clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         exec_valid_r <= 1'b0;
         exec_data_r  <= {DWIDTH{1'b0}};
         exec_ch_r    <= {CW{1'b0}};
         rr_ptr_r     <= {CW{1'b0}};
         for (int c = 0; c < NCH; c++) begin
            key_r[c] <= KEY_INIT;
         end
      end else begin
         exec_valid_r <= issue_s;
         if (issue_s) begin
            exec_data_r <= result_s;
            exec_ch_r   <= win_s;
            rr_ptr_r    <= win_s + CW'(1);
         end
         for (int c = 0; c < NCH; c++) begin
            if (key_wr && (key_ch == CW'(c))) begin
               key_r[c] <= key_data;
            end else if (issue_vec_s[c] && chain_en) begin
               key_r[c] <= result_s;
            end
         end
      end
   end

   // Output FIFO next state; the head is re-registered so odata/och are flops.
   always_comb begin
      opop_s      = ofifo_pop && ordy_r;
      orptr_nxt_s = orptr_r + (opop_s ? OAW'(1) : OAW'(0));
      ocnt_kept_s = ocnt_r - {{OAW{1'b0}}, opop_s};
      ocnt_nxt_s  = ocnt_kept_s + {{OAW{1'b0}}, exec_valid_r};
      if (ocnt_nxt_s == {(OAW+1){1'b0}}) begin
         odata_nxt_s = odata_r;
         och_nxt_s   = och_r;
      end else if (ocnt_kept_s == {(OAW+1){1'b0}}) begin
         // FIFO was empty apart from the word written this edge.
         odata_nxt_s = exec_data_r;
         och_nxt_s   = exec_ch_r;
      end else begin
         odata_nxt_s = odmem_r[orptr_nxt_s];
         och_nxt_s   = ocmem_r[orptr_nxt_s];
      end
   end

   // Output FIFO storage.
   always_ff @(posedge clk) begin
      if (exec_valid_r) begin
         odmem_r[owptr_r] <= exec_data_r;
         ocmem_r[owptr_r] <= exec_ch_r;
      end
   end

   // Output FIFO pointers, count and registered head outputs.
   always_ff @(posedge clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         owptr_r <= {OAW{1'b0}};
         orptr_r <= {OAW{1'b0}};
         ocnt_r  <= {(OAW+1){1'b0}};
         ordy_r  <= 1'b0;
         odata_r <= {DWIDTH{1'b0}};
         och_r   <= {CW{1'b0}};
      end else begin
         if (exec_valid_r) begin
            owptr_r <= owptr_r + OAW'(1);
         end
         orptr_r <= orptr_nxt_s;
         ocnt_r  <= ocnt_nxt_s;
         ordy_r  <= (ocnt_nxt_s != {(OAW+1){1'b0}});
         odata_r <= odata_nxt_s;
         och_r   <= och_nxt_s;
      end
   end

   assign ififo_not_full = not_full_r;
   assign ovf_err        = ovf_r;
   assign ofifo_rdy      = ordy_r;
   assign odata          = odata_r;
   assign och            = och_r;

endmodule
